life_grid_scanner: RTL and testbench
====================================

Name: life_grid_scanner

Overview:
- Raster-order coordinate generator for the Conway cell array.
- On `start`, walks every cell (x fastest, then y) exactly once and presents each coordinate on a valid/ready stream.
- Downstream generation-update logic consumes the stream; an upstream controller issues `start` once per generation and waits for `done`.
- Sits between the generation controller and the cell-update datapath.

Parameters:
- GRID_W, 64, cells per row; minimum 2.
- GRID_H, 48, rows per generation; minimum 2.
- X_WIDTH, $clog2(GRID_W), width of x coordinate.
- Y_WIDTH, $clog2(GRID_H), width of y coordinate.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start  input  1  request a full-grid scan; sampled only in IDLE.
- busy  output  1  high from the cycle after accepted `start` until the last coordinate is accepted.
- done  output  1  one-cycle pulse after the last coordinate is accepted.
- valid  output  1  x/y/first/last/eol are meaningful.
- ready  input  1  consumer accepts the current coordinate when valid&&ready at a rising edge.
- x  output  X_WIDTH  column, 0..GRID_W-1.
- y  output  Y_WIDTH  row, 0..GRID_H-1.
- first  output  1  valid && x==0 && y==0.
- eol  output  1  valid && x==GRID_W-1.
- last  output  1  valid && x==GRID_W-1 && y==GRID_H-1.

Behaviour:
- Reset (any time, including mid-scan):
  - State IDLE.
  - x=0, y=0; busy=0, done=0, valid=0, first=0, eol=0, last=0.
  - Takes effect without a clock edge.
- FSM states IDLE, SCAN, DONE.
- IDLE:
  - Outputs per reset.
  - If start=1 at an edge: go to SCAN, x=0, y=0.
  - Next cycle busy=1, valid=1 (1-cycle latency start->first coordinate).
- SCAN:
  - valid=1, busy=1.
  - On valid&&ready:
    - If x<GRID_W-1: x+1.
    - Else x=0 and y+1.
  - Accepting (GRID_W-1, GRID_H-1) moves to DONE.
  - ready=0 holds x/y/valid stable indefinitely (no coordinate skipped or repeated).
  - start ignored.
- DONE:
  - Exactly one cycle: done=1, busy=0, valid=0, x=0, y=0.
  - Unconditionally returns to IDLE.
  - start in DONE is ignored; the earliest restart is start sampled in the following IDLE cycle.
- Throughput: one coordinate per cycle with ready held high.
  - Full scan = GRID_W*GRID_H cycles of valid, plus 1 DONE cycle.
- first, eol, last are combinational decodes of registered x/y gated by valid; no extra latency.
- Arithmetic:
  - Coordinates are unsigned.
  - Wrap compares against GRID_W-1 / GRID_H-1, never relying on binary overflow, so non-power-of-two sizes are exact.
- done and valid are never high together.

Optional Feature:
- Macro LIFE_SCANNER_NEIGHBOURS_EN.
- Defined: adds outputs x_left, x_right (X_WIDTH) and y_up, y_down (Y_WIDTH).
  - These are the toroidal neighbour coordinates of the current x/y.
  - x_left = (x==0) ? GRID_W-1 : x-1.
  - x_right = (x==GRID_W-1) ? 0 : x+1.
  - y_up / y_down are analogous, using GRID_H.
  - Combinational from registered x/y; reset value follows x=0, y=0 (x_left=GRID_W-1, x_right=1, y_up=GRID_H-1, y_down=1).
  - Qualified by valid.
- Undefined: ports absent; all other behaviour identical.

Decomposition:
- Package life_pkg holds:
  - GRID_W/GRID_H defaults and derived X_WIDTH/Y_WIDTH localparams.
  - Typedefs x_coord_t, y_coord_t.
  - Enum scan_state_t {IDLE, SCAN, DONE}.
- One sub-module, life_axis_counter:
  - Parameters MAX, WIDTH.
  - Ports clk, reset (async active-high), clear, enable, count, wrap.
  - wrap = enable && count==MAX.
  - Instantiated twice: x enabled by valid&&ready; y enabled by x wrap.
- FSM and output decode stay in the top.

Test Plan:
- GRID_W=4, GRID_H=3; ready held 1; start pulse at cycle 0:
  - Cycles 1..12 present (0,0),(1,0),(2,0),(3,0),(0,1)...(3,2).
  - first only at (0,0); eol at x=3; last only at (3,2).
  - done=1 at cycle 13 only; busy=1 for cycles 1..12.
- Backpressure:
  - Drive ready=0 for 3 cycles while at (1,1) -> x=1, y=1, valid=1 held stable.
  - Resume -> next accepted is (2,1); total accepted coordinates = 12, no duplicates.
- start asserted during SCAN at (2,0) and during DONE -> ignored.
  - Scan completes normally with a single done pulse.
  - A new start in the following IDLE restarts at (0,0).
- reset asserted asynchronously mid-cycle at (1,2):
  - Outputs go to reset values before the next edge.
  - After release, no activity until start; then a full 12-coordinate scan.
- Random ready (50%) over 3 back-to-back generations:
  - Each generation yields exactly 12 ordered coordinates and one done pulse.
  - valid&&done never both high.
- With LIFE_SCANNER_NEIGHBOURS_EN:
  - At (0,0): x_left=3, x_right=1, y_up=2, y_down=1.
  - At (3,2): x_left=2, x_right=0, y_up=1, y_down=0.

Source files
------------

// File: rtl/life_pkg.sv
// Shared definitions for the Conway cell-array scanner: default grid size,
// coordinate types and the scan FSM state encoding.
package life_pkg;

    localparam int unsigned GRID_W_DEFAULT = 64;
    localparam int unsigned GRID_H_DEFAULT = 48;
    localparam int unsigned X_WIDTH        = $clog2(GRID_W_DEFAULT);
    localparam int unsigned Y_WIDTH        = $clog2(GRID_H_DEFAULT);

    typedef logic [X_WIDTH-1:0] x_coord_t;
    typedef logic [Y_WIDTH-1:0] y_coord_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } scan_state_t;

endpackage

// File: rtl/life_axis_counter.sv
// Single-axis coordinate counter: counts 0..MAX and wraps to 0 by explicit
// compare, so non-power-of-two ranges are exact. wrap flags the step out of MAX.
module life_axis_counter
    import life_pkg::*;
#(
    parameter int unsigned MAX   = 1,
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX);

    logic [WIDTH-1:0] count_q, count_d;

    // Next count: clear dominates, otherwise step with explicit wrap at MAX.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = (count_q == MaxVal) ? '0 : count_q + WIDTH'(1);
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign wrap  = enable && (count_q == MaxVal);

endmodule

// File: rtl/life_grid_scanner.sv
// Raster-order coordinate generator for the Conway cell array. On start it
// walks every cell once (x fastest) on a valid/ready stream, then pulses done.
// Optional feature: define LIFE_SCANNER_NEIGHBOURS_EN to add toroidal
// neighbour coordinate outputs (x_left, x_right, y_up, y_down).
module life_grid_scanner #(
    parameter int unsigned GRID_W  = life_pkg::GRID_W_DEFAULT,
    parameter int unsigned GRID_H  = life_pkg::GRID_H_DEFAULT,
    parameter int unsigned X_WIDTH = $clog2(GRID_W),
    parameter int unsigned Y_WIDTH = $clog2(GRID_H)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               valid,
    input  logic               ready,
    output logic [X_WIDTH-1:0] x,
    output logic [Y_WIDTH-1:0] y,
`ifdef LIFE_SCANNER_NEIGHBOURS_EN
    output logic [X_WIDTH-1:0] x_left,
    output logic [X_WIDTH-1:0] x_right,
    output logic [Y_WIDTH-1:0] y_up,
    output logic [Y_WIDTH-1:0] y_down,
`endif
    output logic               first,
    output logic               eol,
    output logic               last
);

    import life_pkg::*;

    localparam logic [X_WIDTH-1:0] XMax = X_WIDTH'(GRID_W - 1);
    localparam logic [Y_WIDTH-1:0] YMax = Y_WIDTH'(GRID_H - 1);

    scan_state_t state_q, state_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        valid_q, valid_d;

    logic               accept;
    logic               cnt_clear;
    logic               x_wrap;
    logic               y_wrap;
    logic [X_WIDTH-1:0] x_cnt;
    logic [Y_WIDTH-1:0] y_cnt;

    assign accept    = valid_q && ready;
    // Coordinates sit at the origin whenever no scan is in progress.
    assign cnt_clear = (state_q != SCAN);

    life_axis_counter #(
        .MAX   (GRID_W - 1),
        .WIDTH (X_WIDTH)
    ) u_x_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (accept),
        .count  (x_cnt),
        .wrap   (x_wrap)
    );

    life_axis_counter #(
        .MAX   (GRID_H - 1),
        .WIDTH (Y_WIDTH)
    ) u_y_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (x_wrap),
        .count  (y_cnt),
        .wrap   (y_wrap)
    );

    // FSM next state and next registered outputs; y_wrap marks acceptance of the last cell.
    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        valid_d = valid_q;
        unique case (state_q)
            IDLE: begin
                busy_d  = start;
                valid_d = start;
                if (start) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (y_wrap) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                valid_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign valid = valid_q;
    assign x     = x_cnt;
    assign y     = y_cnt;
    assign first = valid_q && (x_cnt == '0) && (y_cnt == '0);
    assign eol   = valid_q && (x_cnt == XMax);
    assign last  = valid_q && (x_cnt == XMax) && (y_cnt == YMax);

`ifdef LIFE_SCANNER_NEIGHBOURS_EN
    // Toroidal neighbours; left ungated so the idle value follows the origin.
    assign x_left  = (x_cnt == '0)   ? XMax : x_cnt - X_WIDTH'(1);
    assign x_right = (x_cnt == XMax) ? '0   : x_cnt + X_WIDTH'(1);
    assign y_up    = (y_cnt == '0)   ? YMax : y_cnt - Y_WIDTH'(1);
    assign y_down  = (y_cnt == YMax) ? '0   : y_cnt + Y_WIDTH'(1);
`endif

endmodule

// File: tb/tb_life_grid_scanner.sv
// Directed bench for life_grid_scanner on a 4x3 grid with a coordinate scoreboard.
module tb_life_grid_scanner;

    localparam int unsigned W = 4;
    localparam int unsigned H = 3;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       ready = 1'b1;
    logic       busy, done, valid, first, eol, last;
    logic [1:0] x;
    logic [1:0] y;
`ifdef LIFE_SCANNER_NEIGHBOURS_EN
    logic [1:0] x_left, x_right, y_up, y_down;
`endif

    life_grid_scanner #(
        .GRID_W (W),
        .GRID_H (H)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .valid   (valid),
        .ready   (ready),
        .x       (x),
        .y       (y),
`ifdef LIFE_SCANNER_NEIGHBOURS_EN
        .x_left  (x_left),
        .x_right (x_right),
        .y_up    (y_up),
        .y_down  (y_down),
`endif
        .first   (first),
        .eol     (eol),
        .last    (last)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   ex;
        int   ey;
        logic f;
        logic e;
        logic l;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_acc    = 0;
    int   n_done   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic push_scan();
        for (int yy = 0; yy < int'(H); yy++) begin
            for (int xx = 0; xx < int'(W); xx++) begin
                sb.push_back('{xx, yy, (xx == 0 && yy == 0), (xx == 3), (xx == 3 && yy == 2)});
            end
        end
    endtask

    // Score any acceptance at the coming edge, then advance one cycle and check invariants.
    task automatic tick();
        exp_t e;
        if (valid && ready) begin
            n_acc++;
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("x", x, e.ex);
                chk("y", y, e.ey);
                chk("first", first, e.f);
                chk("eol", eol, e.e);
                chk("last", last, e.l);
`ifdef LIFE_SCANNER_NEIGHBOURS_EN
                chk("x_left", x_left, (e.ex == 0) ? 3 : e.ex - 1);
                chk("x_right", x_right, (e.ex == 3) ? 0 : e.ex + 1);
                chk("y_up", y_up, (e.ey == 0) ? 2 : e.ey - 1);
                chk("y_down", y_down, (e.ey == 2) ? 0 : e.ey + 1);
`endif
            end
        end
        @(posedge clk);
        #1;
        chk("valid_done_excl", valid & done, 0);
        chk("busy_eq_valid", busy, valid);
        if (!valid) chk("decode_gated", {first, eol, last}, 0);
        if (done) n_done++;
    endtask

    task automatic wait_done(input int budget, input bit rnd, output int cyc);
        bit seen;
        seen = 1'b0;
        cyc  = 0;
        for (int i = 0; i < budget; i++) begin
            ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            cyc++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        ready = 1'b1;
        chk("done_seen", seen, 1);
        chk("done_x", x, 0);
        chk("done_y", y, 0);
        chk("done_busy", busy, 0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_x"}, x, 0);
        chk({tag, "_y"}, y, 0);
    endtask

    task automatic begin_scan();
        start = 1'b1;
        push_scan();
        tick();
        start = 1'b0;
        chk("start_valid", valid, 1);
        chk("start_busy", busy, 1);
    endtask

    initial begin
        int cyc;
        int acc0;
        int done0;

        // Reset state
        tick();
        tick();
        chk_idle("reset");
        chk("reset_flags", {first, eol, last}, 0);
        reset = 1'b0;
        tick();
        chk_idle("idle");

        // Full scan with ready held high: 12 valid cycles, done on the 13th
        acc0  = n_acc;
        done0 = n_done;
        begin_scan();
        wait_done(100, 1'b0, cyc);
        chk("scan_cycles", cyc, 12);
        chk("scan_acc", n_acc - acc0, 12);
        tick();
        chk_idle("after_done");
        chk("scan_done_pulses", n_done - done0, 1);
        chk("scan_sb_empty", sb.size(), 0);

        // Backpressure at (1,1)
        acc0 = n_acc;
        begin_scan();
        for (int i = 0; i < 5; i++) tick();
        chk("bp_at_x", x, 1);
        chk("bp_at_y", y, 1);
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_x", x, 1);
            chk("bp_hold_y", y, 1);
            chk("bp_hold_valid", valid, 1);
        end
        ready = 1'b1;
        tick();
        chk("bp_next_x", x, 2);
        chk("bp_next_y", y, 1);
        wait_done(100, 1'b0, cyc);
        chk("bp_acc", n_acc - acc0, 12);
        chk("bp_sb_empty", sb.size(), 0);
        tick();

        // start during SCAN and during DONE is ignored
        done0 = n_done;
        begin_scan();
        tick();
        tick();
        chk("ss_at_x", x, 2);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ss_cont_x", x, 3);
        chk("ss_cont_valid", valid, 1);
        wait_done(100, 1'b0, cyc);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_idle("ss_done_ignored");
        tick();
        chk_idle("ss_still_idle");
        chk("ss_done_pulses", n_done - done0, 1);
        chk("ss_sb_empty", sb.size(), 0);
        begin_scan();
        chk("restart_x", x, 0);
        chk("restart_y", y, 0);
        wait_done(100, 1'b0, cyc);
        tick();

        // Asynchronous reset mid-cycle at (1,2)
        begin_scan();
        for (int i = 0; i < 9; i++) tick();
        chk("rst_at_x", x, 1);
        chk("rst_at_y", y, 2);
        #2;
        reset = 1'b1;
        #1;
        chk_idle("async_rst");
        chk("async_rst_flags", {first, eol, last}, 0);
        sb.delete();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk_idle("post_rst");
        acc0 = n_acc;
        begin_scan();
        wait_done(100, 1'b0, cyc);
        chk("post_rst_acc", n_acc - acc0, 12);
        tick();

        // Three back-to-back generations with random ready
        for (int g = 0; g < 3; g++) begin
            acc0  = n_acc;
            done0 = n_done;
            begin_scan();
            wait_done(400, 1'b1, cyc);
            tick();
            chk("gen_acc", n_acc - acc0, 12);
            chk("gen_done_pulses", n_done - done0, 1);
            chk("gen_sb_empty", sb.size(), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
